// File: rtl/vga_scan_ctrl.sv
// Raster timing generator and pixel output stage: scan counters, coordinates for the
// renderers, and sync/blank delayed to line up with the returned pixel data.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [11:0] pixel_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        req_valid,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick,
  output logic        line_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_lat
    $error("vga_scan_ctrl: PIPE_LAT must be within 1..4");
  end

  logic [HW-1:0] h_cnt_p0;
  logic [VW-1:0] v_cnt_p0;
  logic          run_p0;
  logic          h_act_p0;
  logic          v_act_p0;
  logic          de_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic [PIPE_LAT-1:0] de_p1;
  logic [PIPE_LAT-1:0] hs_p1;
  logic [PIPE_LAT-1:0] vs_p1;

  // run_p0 holds the counters at (0,0) for the release edge so the first cycle out of
  // reset is a frame start, and masks the ticks while reset is held.
  always_ff @(posedge vga_clk) begin
    if (!vga_rst) begin
      run_p0   <= 1'b0;
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else begin
      run_p0 <= 1'b1;
      if (run_p0) begin
        if (h_cnt_p0 == H_MAX) begin
          h_cnt_p0 <= '0;
          v_cnt_p0 <= (v_cnt_p0 == V_MAX) ? '0 : v_cnt_p0 + 1'b1;
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 1'b1;
        end
      end
    end
  end

  // Stage 0: coordinates, raw timing and ticks decoded from the counter registers
  always_comb begin
    h_act_p0   = (h_cnt_p0 < H_ACT);
    v_act_p0   = (v_cnt_p0 < V_ACT);
    x_pos      = h_act_p0 ? 10'(h_cnt_p0) : 10'd0;
    y_pos      = v_act_p0 ? 10'(v_cnt_p0) : 10'd0;
    req_valid  = run_p0 && h_act_p0 && v_act_p0;
    de_p0      = req_valid;
    hs_p0      = run_p0 && (h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END);
    vs_p0      = run_p0 && (v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END);
    line_tick  = run_p0 && (h_cnt_p0 == '0);
    frame_tick = line_tick && (v_cnt_p0 == '0);
  end

  // Stage 1: PIPE_LAT-deep delay matching the renderer latency; stage 2: output pins
  always_ff @(posedge vga_clk) begin
    if (!vga_rst) begin
      de_p1 <= '0;
      hs_p1 <= '0;
      vs_p1 <= '0;
      hs    <= ~SYNC_POL;
      vs    <= ~SYNC_POL;
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
    end else begin
      de_p1 <= PIPE_LAT'({de_p1, de_p0});
      hs_p1 <= PIPE_LAT'({hs_p1, hs_p0});
      vs_p1 <= PIPE_LAT'({vs_p1, vs_p0});
      hs    <= hs_p1[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
      vs    <= vs_p1[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
      vga_r <= de_p1[PIPE_LAT-1] ? pixel_data[3:0]  : 4'h0;
      vga_g <= de_p1[PIPE_LAT-1] ? pixel_data[7:4]  : 4'h0;
      vga_b <= de_p1[PIPE_LAT-1] ? pixel_data[11:8] : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: three instances (default, inverted sync with deeper pipe,
// tiny raster) checked against an arithmetic raster model plus directed vectors.
module tb_vga_scan_ctrl;

  typedef struct {
    int hact; int hfp; int hsy; int hbp;
    int vact; int vfp; int vsy; int vbp;
    int lat;  bit pol;
  } cfg_t;

  typedef struct {
    int cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic hs;
    logic ft;
    logic lt;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [11:0] pix_a, pix_b, pix_c;
  logic [11:0] pa_q, pb_q, pc_q;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic rv_a, hs_a, vs_a, ft_a, lt_a;
  logic rv_b, hs_b, vs_b, ft_b, lt_b;
  logic rv_c, hs_c, vs_c, ft_c, lt_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_rst = 1'b1;
  bit armed = 1'b0;
  int mode = 0;
  int last_ft_c = -1;
  logic [9:0] xa_last = 10'd0;
  cfg_t ca, cb, cc;

  vga_scan_ctrl u_a (
    .vga_clk(clk), .vga_rst(rst_n), .pixel_data(pix_a),
    .x_pos(x_a), .y_pos(y_a), .req_valid(rv_a), .hs(hs_a), .vs(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_tick(ft_a), .line_tick(lt_a));

  vga_scan_ctrl #(.SYNC_POL(1'b1), .PIPE_LAT(3)) u_b (
    .vga_clk(clk), .vga_rst(rst_n), .pixel_data(pix_b),
    .x_pos(x_b), .y_pos(y_b), .req_valid(rv_b), .hs(hs_b), .vs(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_tick(ft_b), .line_tick(lt_b));

  vga_scan_ctrl #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                  .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_LAT(2)) u_c (
    .vga_clk(clk), .vga_rst(rst_n), .pixel_data(pix_c),
    .x_pos(x_c), .y_pos(y_c), .req_valid(rv_c), .hs(hs_c), .vs(vs_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .frame_tick(ft_c), .line_tick(lt_c));

  // Expected outputs at cycle c after release, from modular raster arithmetic.
  function automatic logic [36:0] model(input cfg_t k, input int c, input bit rst,
                                        input logic [11:0] pprev);
    int ht, vt, h, v, s, sh, sv;
    logic [9:0] x, y;
    logic rv, hsx, vsx, ft, lt, de;
    logic [11:0] rgb;
    if (rst) return {20'd0, 1'b0, ~k.pol, ~k.pol, 12'd0, 2'b00};
    ht = k.hact + k.hfp + k.hsy + k.hbp;
    vt = k.vact + k.vfp + k.vsy + k.vbp;
    h = c % ht;
    v = (c / ht) % vt;
    x = (h < k.hact) ? 10'(h) : 10'd0;
    y = (v < k.vact) ? 10'(v) : 10'd0;
    rv = (h < k.hact) && (v < k.vact);
    lt = (h == 0);
    ft = (h == 0) && (v == 0);
    s = c - k.lat - 1;
    de = 1'b0;
    hsx = ~k.pol;
    vsx = ~k.pol;
    if (s >= 0) begin
      sh = s % ht;
      sv = (s / ht) % vt;
      de = (sh < k.hact) && (sv < k.vact);
      if (sh >= k.hact + k.hfp && sh < k.hact + k.hfp + k.hsy) hsx = k.pol;
      if (sv >= k.vact + k.vfp && sv < k.vact + k.vfp + k.vsy) vsx = k.pol;
    end
    rgb = de ? pprev : 12'd0;
    return {x, y, rv, hsx, vsx, rgb, ft, lt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (!(!in_rst && cyc == target) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10000) chk($sformatf("timeout_wait_c%0d", target), 64'd0, 64'd1);
  endtask

  always @(posedge clk) begin
    pa_q <= pix_a;
    pb_q <= pix_b;
    pc_q <= pix_c;
    if (!rst_n) begin
      in_rst <= 1'b1;
      cyc    <= 0;
      armed  <= 1'b1;
    end else if (in_rst) begin
      in_rst <= 1'b0;
      cyc    <= 0;
    end else begin
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk($sformatf("model_a_c%0d", cyc),
          64'({x_a, y_a, rv_a, hs_a, vs_a, b_a, g_a, r_a, ft_a, lt_a}),
          64'(model(ca, cyc, in_rst, pa_q)));
      chk($sformatf("model_b_c%0d", cyc),
          64'({x_b, y_b, rv_b, hs_b, vs_b, b_b, g_b, r_b, ft_b, lt_b}),
          64'(model(cb, cyc, in_rst, pb_q)));
      chk($sformatf("model_c_c%0d", cyc),
          64'({x_c, y_c, rv_c, hs_c, vs_c, b_c, g_c, r_c, ft_c, lt_c}),
          64'(model(cc, cyc, in_rst, pc_q)));
      if (in_rst) begin
        last_ft_c <= -1;
      end else if (ft_c) begin
        if (last_ft_c >= 0) chk("frame_period_c", 64'(cyc - last_ft_c), 64'd544);
        last_ft_c <= cyc;
      end
    end
  end

  // Pixel sources: constant green, coordinate echo with one-cycle renderer delay, or random.
  initial begin
    pix_a = 12'h0; pix_b = 12'h0; pix_c = 12'h0;
    forever begin
      @(negedge clk);
      case (mode)
        0: begin pix_a = 12'h0f0; pix_b = 12'h0f0; pix_c = 12'h0f0; end
        1: begin pix_a = {2'b00, xa_last}; pix_b = 12'($urandom); pix_c = 12'($urandom); end
        default: begin pix_a = 12'($urandom); pix_b = 12'($urandom); pix_c = 12'($urandom); end
      endcase
      xa_last = x_a;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0};
    cb = '{640, 16, 96, 48, 480, 10, 2, 33, 3, 1'b1};
    cc = '{16, 4, 6, 6, 10, 2, 2, 3, 2, 1'b0};
    tbl[0]  = '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[1]  = '{1,   10'd1,   10'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[2]  = '{2,   10'd2,   10'd0, 1'b1, 1'b0, 1'b0, 12'h0f0};
    tbl[3]  = '{639, 10'd639, 10'd0, 1'b1, 1'b0, 1'b0, 12'h0f0};
    tbl[4]  = '{640, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h0f0};
    tbl[5]  = '{641, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h0f0};
    tbl[6]  = '{642, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[7]  = '{657, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[8]  = '{658, 10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[9]  = '{753, 10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[10] = '{754, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[11] = '{799, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[12] = '{800, 10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[13] = '{801, 10'd1,   10'd1, 1'b1, 1'b0, 1'b0, 12'h000};
    tbl[14] = '{802, 10'd2,   10'd1, 1'b1, 1'b0, 1'b0, 12'h0f0};

    rst_n = 1'b0;
    mode = 0;
    repeat (4) @(negedge clk);
    chk("reset_state_a", 64'({x_a, y_a, rv_a, hs_a, vs_a, b_a, g_a, r_a, ft_a, lt_a}),
        64'({20'd0, 1'b0, 1'b1, 1'b1, 12'd0, 2'b00}));
    chk("reset_sync_b", 64'({hs_b, vs_b}), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      wait_cyc(tbl[k].cyc);
      chk($sformatf("vec%0d_c%0d", k, tbl[k].cyc),
          64'({x_a, y_a, hs_a, ft_a, lt_a, b_a, g_a, r_a}),
          64'({tbl[k].x, tbl[k].y, tbl[k].hs, tbl[k].ft, tbl[k].lt, tbl[k].rgb}));
    end

    mode = 1;
    wait_cyc(1603);
    chk("echo_x1", 64'({b_a, g_a, r_a}), 64'h001);
    wait_cyc(2241);
    chk("echo_x639", 64'({b_a, g_a, r_a}), 64'h27f);
    wait_cyc(2242);
    chk("echo_blank", 64'({b_a, g_a, r_a}), 64'h000);
    wait_cyc(2259);
    chk("hs_b_659", 64'(hs_b), 64'd0);
    wait_cyc(2260);
    chk("hs_b_660", 64'(hs_b), 64'd1);
    wait_cyc(2355);
    chk("hs_b_755", 64'(hs_b), 64'd1);
    wait_cyc(2356);
    chk("hs_b_756", 64'(hs_b), 64'd0);

    mode = 2;
    wait_cyc(4700);
    chk("hs_a_in_sync_before_rst", 64'(hs_a), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_a", 64'({x_a, y_a, rv_a, hs_a, b_a, g_a, r_a, ft_a, lt_a}),
        64'({20'd0, 1'b0, 1'b1, 12'd0, 2'b00}));
    chk("midrst_b_sync", 64'({hs_b, vs_b}), 64'd0);
    repeat (2) @(negedge clk);
    chk("held_rst_ticks_a", 64'({ft_a, lt_a, rv_a}), 64'd0);
    rst_n = 1'b1;
    wait_cyc(0);
    chk("restart_ticks_a", 64'({ft_a, lt_a, x_a, y_a}), 64'({2'b11, 20'd0}));
    wait_cyc(657);
    chk("restart_hs_657", 64'(hs_a), 64'd1);
    wait_cyc(658);
    chk("restart_hs_658", 64'(hs_a), 64'd0);
    wait_cyc(3200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Raster timing generator and pixel output stage on the display side of the game pages.
- Produces the x_pos/y_pos scan coordinates that every page renderer consumes.
- Takes back each renderer's registered 12-bit pixel_data and drives the monitor's sync and RGB pins.
- Delays sync and blanking to match the renderer pipeline, so every output pixel lines up with its coordinate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hs/vs (0 = active-low)
- PIPE_LAT, 1, renderer latency in clocks, from x_pos/y_pos to matching pixel_data (1..4)

Ports:
- vga_clk  input  1  pixel clock; all logic on rising edge
- vga_rst  input  1  synchronous, active-low reset
- pixel_data  input  12  renderer pixel, {B[11:8],G[7:4],R[3:0]}
- x_pos  output  10  current column; 0 when horizontally blanked
- y_pos  output  10  current row; 0 when vertically blanked
- req_valid  output  1  x_pos/y_pos lie inside the active area
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue
- frame_tick  output  1  one-cycle pulse at start of each frame
- line_tick  output  1  one-cycle pulse at start of each line

Behaviour:
Counters and coordinates
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt advances only on the h_cnt wrap. It runs 0..V_TOTAL-1 and wraps to 0 when both counters are at their maxima.
- x_pos = h_cnt when h_cnt<H_ACTIVE, else 0. y_pos = v_cnt when v_cnt<V_ACTIVE, else 0.
- Both are decoded from counter registers only, so they carry no combinational path from inputs.
- req_valid = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).

Raw timing (stage 0, cycle t)
- de_raw = req_valid.
- hs_raw is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs_raw is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Asserted means the output level equals SYNC_POL.

Alignment pipeline
- de_raw, hs_raw and vs_raw pass through a PIPE_LAT-deep shift register, then a final output register.
- The output register samples pixel_data.
- vga_{b,g,r} <= de_d ? pixel_data fields : 0.
- hs, vs, vga_* at cycle t+PIPE_LAT+1 all reflect the coordinate issued at cycle t.
- RGB is forced to 0 whenever the delayed de is low, whatever pixel_data is.

Ticks
- frame_tick is high during exactly the cycles where h_cnt==0 && v_cnt==0. This includes the first cycle after reset release.
- line_tick is high for every h_cnt==0.
- Both are stage-0 aligned, not delayed.

Reset (vga_rst==0 sampled on a rising edge)
- Counters go to 0; all shift stages are cleared to de=0 and sync deasserted.
- hs = vs = ~SYNC_POL; vga_r/g/b = 0.
- x_pos = y_pos = 0; req_valid, frame_tick and line_tick are forced to 0 while reset is held.
- Reset mid-frame aborts the frame immediately. No partial sync pulse continues once the reset edge is taken.
- After release, scanning restarts at (0,0) with frame_tick high in the first cycle.

Other rules
- Counter widths are sized to hold H_TOTAL-1 and V_TOTAL-1; overflow is impossible by construction.
- PIPE_LAT outside 1..4 is a synthesis error.

Test Plan:
1. Release reset, default params → frame_tick high in cycle 0; next frame_tick exactly 420000 cycles later; line_tick every 800 cycles.
2. Line timing → hs low from line-relative cycle 658 to 753 inclusive (656..751 plus 2-cycle lag), high elsewhere; vs low for lines 490..491, shifted by 2 clocks.
3. Drive pixel_data = 12'h0f0 constant → vga_g = 4'hf and vga_r = vga_b = 0 from cycle 2 to cycle 641 of each active line; all RGB 0 in cycles 642..801 and on lines 480..524.
4. Coordinate echo: renderer model returns {2'b0, x_pos} one cycle later → the RGB output at cycle t+2 equals the x_pos of cycle t for every active pixel; check x=0, 639 and y=479.
5. Assert vga_rst low at line 300, h_cnt 700 (inside hsync) → next edge hs = 1, RGB = 0, x_pos = y_pos = 0; after release, frame_tick high in first cycle and hs asserts at line-relative cycle 658.
6. SYNC_POL = 1, PIPE_LAT = 3 → hs high for line-relative cycles 660..755; RGB aligned 4 cycles after coordinate; reset levels hs = vs = 0.
